// File: rtl/mfp_timer_gen.sv
// Parametrised MFP68901-style timer: programmable prescaler, down-counter with reload,
// delay / event / pulse-width modes, one-shot, selectable trigger polarity and read latch.
//
//   mode        | meaning
//   MODE_STOP   | counter held, prescaler held at 0, DAT_WE loads counter directly
//   MODE_DELAY  | counter decrements on every prescaler tick
//   MODE_EVENT  | counter decrements on each active edge of the delayed trigger
//   MODE_PULSE  | counter decrements on prescaler tick while trigger is active (gate)
module mfp_timer_gen #(
   parameter int CNT_W       = 8,
   parameter int PSC_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TRIG_DLY    = 4
) (
   input  logic             XCLK_I,
   input  logic             RST,
   input  logic             DAT_WE,
   input  logic [CNT_W-1:0] DAT_I,
   output logic [CNT_W-1:0] DAT_O,
   input  logic             RD_LATCH,
   input  logic             PSC_WE,
   input  logic [PSC_W-1:0] PSC_I,
   input  logic             CTRL_WE,
   input  logic [5:0]       CTRL_I,
   output logic [3:0]       CTRL_O,
   input  logic             T_I,
   output logic             T_O,
   output logic             T_O_PULSE,
   output logic             EVENT_MODE,
   output logic             PULSE_MODE,
   output logic [CNT_W-1:0] DATA_OUT
);

   typedef enum logic [1:0] {
      MODE_STOP  = 2'd0,
      MODE_DELAY = 2'd1,
      MODE_EVENT = 2'd2,
      MODE_PULSE = 2'd3
   } mode_t;

   mode_t                  mode_q, mode_d;
   logic                   oneshot_q, oneshot_d;
   logic                   pol_q, pol_d;
   logic [CNT_W-1:0]       data_q, data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PSC_W-1:0]       psc_q, psc_d;
   logic [PSC_W-1:0]       psc_cnt_q, psc_cnt_d;
   logic [CNT_W-1:0]       latch_q, latch_d;
   logic                   t_o_q, t_o_d;
   logic                   pulse_q, pulse_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   trig_prev_q;

   logic             trig_raw;
   logic             trig;
   logic             trig_edge;
   logic             psc_run;
   logic             tick;
   logic             count_en;
   logic             timeout;
   logic             mode_chg;
   logic [CNT_W-1:0] reload_val;
   logic             ctrl_unused;

   assign ctrl_unused = CTRL_I[5];

   generate
      if (TRIG_DLY > 0) begin : g_dly
         logic [TRIG_DLY-1:0] dly_q;
         always_ff @(posedge XCLK_I) begin
            if (RST) dly_q <= '0;
            else     dly_q <= (dly_q << 1) | TRIG_DLY'(sync_q[SYNC_STAGES-1]);
         end
         assign trig_raw = dly_q[TRIG_DLY-1];
      end else begin : g_nodly
         assign trig_raw = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_comb begin
      trig       = trig_raw ^ pol_q;
      trig_edge  = trig & ~trig_prev_q;
      psc_run    = (mode_q == MODE_DELAY) || (mode_q == MODE_PULSE);
      tick       = psc_run && (psc_cnt_q == psc_q);
      mode_chg   = CTRL_WE && (CTRL_I[1:0] != mode_q);
      reload_val = DAT_WE ? DAT_I : data_q;

      count_en = 1'b0;
      unique case (mode_q)
         MODE_STOP:  count_en = 1'b0;
         MODE_DELAY: count_en = tick;
         MODE_EVENT: count_en = trig_edge;
         MODE_PULSE: count_en = tick & trig;
      endcase
      timeout = count_en && (cnt_q == CNT_W'(1));

      psc_d = PSC_WE ? PSC_I : psc_q;
      if (PSC_WE || mode_chg || !psc_run || tick) psc_cnt_d = '0;
      else                                       psc_cnt_d = psc_cnt_q + PSC_W'(1);

      data_d = DAT_WE ? DAT_I : data_q;

      // Counter 0 wraps to all-ones, so data==0 yields a full 2^CNT_W period.
      cnt_d = cnt_q;
      if (DAT_WE && (mode_q == MODE_STOP)) cnt_d = DAT_I;
      else if (count_en)                   cnt_d = timeout ? reload_val : cnt_q - CNT_W'(1);

      mode_d    = mode_q;
      oneshot_d = oneshot_q;
      pol_d     = pol_q;
      if (timeout && oneshot_q) mode_d = MODE_STOP;
      if (CTRL_WE) begin
         mode_d    = mode_t'(CTRL_I[1:0]);
         oneshot_d = CTRL_I[2];
         pol_d     = CTRL_I[3];
      end

      // An explicit clear wins over a toggle landing in the same cycle.
      t_o_d = t_o_q ^ timeout;
      if (CTRL_WE && CTRL_I[4]) t_o_d = 1'b0;
      pulse_d = timeout;

      latch_d = RD_LATCH ? cnt_q : latch_q;
   end

   always_ff @(posedge XCLK_I) begin
      if (RST) begin
         mode_q      <= MODE_STOP;
         oneshot_q   <= 1'b0;
         pol_q       <= 1'b0;
         data_q      <= '0;
         cnt_q       <= '0;
         psc_q       <= '0;
         psc_cnt_q   <= '0;
         latch_q     <= '0;
         t_o_q       <= 1'b0;
         pulse_q     <= 1'b0;
         sync_q      <= '0;
         trig_prev_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         oneshot_q   <= oneshot_d;
         pol_q       <= pol_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         psc_q       <= psc_d;
         psc_cnt_q   <= psc_cnt_d;
         latch_q     <= latch_d;
         t_o_q       <= t_o_d;
         pulse_q     <= pulse_d;
         sync_q      <= {sync_q[SYNC_STAGES-2:0], T_I};
         trig_prev_q <= trig;
      end
   end

   assign DAT_O      = latch_q;
   assign CTRL_O     = {pol_q, oneshot_q, mode_q};
   assign T_O        = t_o_q;
   assign T_O_PULSE  = pulse_q;
   assign EVENT_MODE = (mode_q == MODE_EVENT);
   assign PULSE_MODE = (mode_q == MODE_PULSE);
   assign DATA_OUT   = data_q;

endmodule

// File: tb/tb_mfp_timer_gen.sv
// Directed bench for mfp_timer_gen: expected timeout strobes are queued with their cycle
// and T_O value; a forked monitor pops and compares on every T_O_PULSE.
module tb_mfp_timer_gen;

   localparam int CNT_W = 8;
   localparam int PSC_W = 8;

   logic             XCLK_I = 1'b0;
   logic             RST;
   logic             DAT_WE;
   logic [CNT_W-1:0] DAT_I;
   logic [CNT_W-1:0] DAT_O;
   logic             RD_LATCH;
   logic             PSC_WE;
   logic [PSC_W-1:0] PSC_I;
   logic             CTRL_WE;
   logic [5:0]       CTRL_I;
   logic [3:0]       CTRL_O;
   logic             T_I;
   logic             T_O;
   logic             T_O_PULSE;
   logic             EVENT_MODE;
   logic             PULSE_MODE;
   logic [CNT_W-1:0] DATA_OUT;

   typedef struct packed {
      int   cyc;
      logic t_o;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   w, w2, c;

   mfp_timer_gen #(
      .CNT_W(CNT_W), .PSC_W(PSC_W), .SYNC_STAGES(2), .TRIG_DLY(4)
   ) dut (
      .XCLK_I(XCLK_I), .RST(RST),
      .DAT_WE(DAT_WE), .DAT_I(DAT_I), .DAT_O(DAT_O),
      .RD_LATCH(RD_LATCH),
      .PSC_WE(PSC_WE), .PSC_I(PSC_I),
      .CTRL_WE(CTRL_WE), .CTRL_I(CTRL_I), .CTRL_O(CTRL_O),
      .T_I(T_I), .T_O(T_O), .T_O_PULSE(T_O_PULSE),
      .EVENT_MODE(EVENT_MODE), .PULSE_MODE(PULSE_MODE),
      .DATA_OUT(DATA_OUT)
   );

   always #5 XCLK_I = ~XCLK_I;
   always @(posedge XCLK_I) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int pc, input logic pt);
      exp_t e;
      e.cyc = pc;
      e.t_o = pt;
      sb.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge XCLK_I);
         if (T_O_PULSE === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: got T_O_PULSE at cycle %0d, required none", cyc);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || T_O !== e.t_o) begin
                  errors++;
                  $display("FAIL pulse: got cycle %0d T_O=%0b, required cycle %0d T_O=%0b",
                           cyc, T_O, e.cyc, e.t_o);
               end
            end
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge XCLK_I);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge XCLK_I);
   endtask

   task automatic wr_ctrl(input logic [5:0] v, output int wc);
      CTRL_WE = 1'b1;
      CTRL_I  = v;
      wc      = cyc + 1;
      @(negedge XCLK_I);
      CTRL_WE = 1'b0;
   endtask

   task automatic wr_dat(input logic [CNT_W-1:0] v);
      DAT_WE = 1'b1;
      DAT_I  = v;
      @(negedge XCLK_I);
      DAT_WE = 1'b0;
   endtask

   task automatic wr_psc(input logic [PSC_W-1:0] v);
      PSC_WE = 1'b1;
      PSC_I  = v;
      @(negedge XCLK_I);
      PSC_WE = 1'b0;
   endtask

   task automatic latch_at(input int t, input logic [CNT_W-1:0] e, input string nm);
      wait_until(t);
      RD_LATCH = 1'b1;
      @(negedge XCLK_I);
      RD_LATCH = 1'b0;
      chk(nm, 32'(DAT_O), 32'(e));
   endtask

   task automatic sb_check(input string nm);
      chk(nm, 32'(sb.size()), 0);
      sb.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dat_o"},      32'(DAT_O), 0);
      chk({tag, "_ctrl_o"},     32'(CTRL_O), 0);
      chk({tag, "_t_o"},        32'(T_O), 0);
      chk({tag, "_t_o_pulse"},  32'(T_O_PULSE), 0);
      chk({tag, "_data_out"},   32'(DATA_OUT), 0);
      chk({tag, "_event_mode"}, 32'(EVENT_MODE), 0);
      chk({tag, "_pulse_mode"}, 32'(PULSE_MODE), 0);
   endtask

   initial begin
      RST = 1'b1; DAT_WE = 1'b0; DAT_I = '0; RD_LATCH = 1'b0;
      PSC_WE = 1'b0; PSC_I = '0; CTRL_WE = 1'b0; CTRL_I = '0; T_I = 1'b0;
      fork
         monitor();
      join_none
      step(3);
      chk_all_zero("reset");
      RST = 1'b0;
      step(1);

      // delay mode, PSC=3, data=3: strobe every 12 cycles
      wr_psc(3);
      wr_dat(3);
      wr_ctrl(6'h01, w);
      push(w + 12, 1'b1); push(w + 24, 1'b0); push(w + 36, 1'b1);
      chk("t1_ctrl_o", 32'(CTRL_O), 1);
      latch_at(w + 1, 3, "t1_latch_3");
      latch_at(w + 5, 2, "t1_latch_2");
      latch_at(w + 9, 1, "t1_latch_1");
      latch_at(w + 13, 3, "t1_latch_reload");
      wait_until(w + 40);
      wr_ctrl(6'h10, w2);
      chk("t1_t_o_clear", 32'(T_O), 0);
      sb_check("t1_sb_empty");

      // event mode, data=2, 5 rising edges
      wr_dat(2);
      wr_ctrl(6'h02, w);
      chk("t2_event_mode", 32'(EVENT_MODE), 1);
      for (int k = 1; k <= 5; k++) begin
         c = cyc;
         T_I = 1'b1;
         if (k == 2) push(c + 7, 1'b1);
         if (k == 4) push(c + 7, 1'b0);
         step(4);
         T_I = 1'b0;
         step(4);
      end
      step(10);
      wr_ctrl(6'h00, w);
      sb_check("t2_sb_empty");

      // pulse mode, PSC=0, data=4, gate high 6 cycles
      wr_psc(0);
      wr_dat(4);
      wr_ctrl(6'h03, w);
      chk("t3_pulse_mode", 32'(PULSE_MODE), 1);
      step(3);
      c = cyc;
      T_I = 1'b1;
      push(c + 10, 1'b1);
      step(6);
      T_I = 1'b0;
      step(15);
      wr_ctrl(6'h00, w);
      sb_check("t3_sb_empty");

      // pulse mode, inverted polarity, T_I held high: gate never opens
      T_I = 1'b1;
      step(12);
      wr_ctrl(6'h0B, w);
      chk("t4_ctrl_o", 32'(CTRL_O), 32'h0B);
      step(30);
      wr_ctrl(6'h00, w);
      T_I = 1'b0;
      step(12);
      sb_check("t4_sb_empty");

      // one-shot delay, data=5
      wr_dat(5);
      wr_ctrl(6'h05, w);
      push(w + 5, 1'b0);
      wait_until(w + 5);
      chk("t5_mode_cleared", 32'(CTRL_O), 32'h04);
      step(20);
      latch_at(cyc, 5, "t5_counter_held");
      sb_check("t5_sb_empty");

      // event mode, data=0: 256 edges per timeout
      wr_dat(0);
      wr_ctrl(6'h02, w);
      for (int k = 1; k <= 256; k++) begin
         c = cyc;
         T_I = 1'b1;
         if (k == 256) push(c + 7, 1'b1);
         step(2);
         T_I = 1'b0;
         step(2);
      end
      step(12);
      wr_ctrl(6'h00, w);
      sb_check("t6_sb_empty");

      // data write while running, then forced T_O clear on a timeout cycle
      wr_dat(8);
      wr_ctrl(6'h01, w);
      push(w + 8, 1'b0);
      push(w + 17, 1'b0);
      step(2);
      wr_dat(9);
      chk("t7_data_out", 32'(DATA_OUT), 9);
      latch_at(w + 3, 5, "t7_continues");
      latch_at(w + 8, 9, "t7_reload_new");
      wait_until(w + 16);
      wr_ctrl(6'h11, w2);
      chk("t9_t_o_forced", 32'(T_O), 0);
      wr_ctrl(6'h00, w2);
      sb_check("t7_sb_empty");

      // reset mid-count, one cycle before a timeout
      wr_dat(3);
      wr_ctrl(6'h01, w);
      push(w + 3, 1'b1);
      latch_at(w + 4, 2, "t8_latch");
      chk("t8_t_o_before", 32'(T_O), 1);
      RST = 1'b1;
      step(1);
      chk_all_zero("t8_rst");
      RST = 1'b0;
      step(5);
      sb_check("t8_sb_empty");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
